fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 45 ++++
 rtl/fifo_wr_arbiter_rr_select.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the two-state FSM encoding and the round-robin search used by rr_select.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // The search helper works on a fixed 16-lane vector; narrower request
    // vectors are zero-extended by the caller and `num` bounds the search.
    localparam int unsigned RR_MAX_REQ = 16;
    localparam int unsigned RR_IDX_W   = 4;
    localparam int unsigned RR_POS_W   = 5;

    // Returns {found, index} of the first set request at or above `start`,
    // wrapping modulo `num`.
    function automatic logic [RR_POS_W-1:0] rr_search(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   start,
        input logic [RR_POS_W-1:0]   num
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_POS_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            pos = {1'b0, start} + RR_POS_W'(i);
            if (pos >= num) begin
                pos = pos - num;
            end else begin
                pos = pos;
            end
            if ((i < int'(num)) && !found && req[pos[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[RR_IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational round-robin priority selector: finds the first requesting
// port at or above the start pointer, wrapping around NUM_REQ.
module rr_select
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [RR_MAX_REQ-1:0] req_ext_s;
    logic [RR_IDX_W-1:0]   start_ext_s;
    logic [RR_POS_W-1:0]   result_s;

    // Widen the inputs to the helper's fixed lane count and split its result.
    always_comb begin
        req_ext_s   = RR_MAX_REQ'(req_i);
        start_ext_s = RR_IDX_W'(start_i);
        result_s    = rr_search(req_ext_s, start_ext_s, RR_POS_W'(NUM_REQ));
        idx_o       = IDX_W'(result_s[RR_IDX_W-1:0]);
        any_o       = result_s[RR_IDX_W];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ producers share one sync-FIFO write
// port. An owner keeps the port for up to MAX_BURST words or until it drops
// valid; the next search then starts just above the previous owner.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]              ready_o,
    input  logic                            fifo_full_i,
    output logic                            fifo_write_o,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
    output logic                            busy_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0]   burst_q, burst_d;

    logic [IDX_W-1:0]      sel_idx_s;
    logic                  sel_any_s;
    logic [NUM_REQ-1:0]    owner_mask_s;
    logic                  owner_valid_s;
    logic [DATA_WIDTH-1:0] owner_data_s;
    logic [IDX_W-1:0]      rr_after_s;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req_i   (valid_i),
        .start_i (rr_ptr_q),
        .idx_o   (sel_idx_s),
        .any_o   (sel_any_s)
    );

    // Decode the owner into a one-hot lane mask and pick out its valid/data lanes.
    always_comb begin
        owner_mask_s  = '0;
        owner_valid_s = 1'b0;
        owner_data_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_mask_s[k] = 1'b1;
                owner_valid_s   = valid_i[k];
                owner_data_s    = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                owner_mask_s[k] = 1'b0;
            end
        end
        if (owner_q == IDX_W'(NUM_REQ-1)) begin
            rr_after_s = '0;
        end else begin
            rr_after_s = owner_q + IDX_W'(1'b1);
        end
    end

    // FSM next state, burst bookkeeping and the combinational handshake outputs.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        burst_d        = burst_q;
        rr_ptr_d       = rr_ptr_q;
        ready_o        = '0;
        fifo_write_o   = 1'b0;
        fifo_wr_data_o = '0;
        case (state_q)
            IDLE: begin
                if (sel_any_s) begin
                    owner_d = sel_idx_s;
                    burst_d = '0;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Only the owner lane can be ready, and never into a full FIFO.
                ready_o        = owner_mask_s & {NUM_REQ{!fifo_full_i}};
                fifo_write_o   = owner_valid_s & !fifo_full_i;
                fifo_wr_data_o = owner_data_s;
                if (!owner_valid_s) begin
                    // Owner let go: release without a transfer this cycle.
                    state_d  = IDLE;
                    rr_ptr_d = rr_after_s;
                    burst_d  = '0;
                end else if (fifo_full_i) begin
                    // Stalled: keep owner and burst count exactly as they are.
                    state_d = GRANT;
                end else if (burst_q == BCNT_W'(MAX_BURST-1)) begin
                    // Last word of the burst transfers now, then hand over.
                    state_d  = IDLE;
                    rr_ptr_d = rr_after_s;
                    burst_d  = '0;
                end else begin
                    burst_d = burst_q + BCNT_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst and restarts the search at port 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    // Status outputs come straight from the state registers.
    always_comb begin
        busy_o     = (state_q == GRANT);
        grant_id_o = owner_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues drive the ports,
// every accepted word is checked against a per-port expected queue, and
// directed scenarios check grant order, stalls, release and reset.
module tb_fifo_wr_arbiter;

    localparam int NR         = 4;
    localparam int DW         = 32;
    localparam int MB         = 4;
    localparam int WAIT_BOUND = (NR-1)*MB;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [NR-1:0]     valid_i;
    logic [NR*DW-1:0]  data_i;
    logic [NR-1:0]     ready_o;
    logic              fifo_full_i;
    logic              fifo_write_o;
    logic [DW-1:0]     fifo_wr_data_o;
    logic [1:0]        grant_id_o;
    logic              busy_o;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_write_o   (fifo_write_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] pq    [NR][$];   // words each producer still has to send
    logic [DW-1:0] exp_q [NR][$];   // scoreboard: words the FIFO must receive, per port
    logic [NR-1:0] en = '1;
    logic          full_knob = 1'b0;
    logic          rand_full = 1'b0;
    logic          trace_on = 1'b0;
    logic [7:0]    scen = 8'd0;
    int            seq_cnt [NR];
    int            wait_cnt [NR];
    int            xfer_log [$];
    int            trace [$];
    int            run_port [$];
    int            run_len [$];
    int            checks = 0;
    int            failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_words(input int k, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {8'(k), scen, 16'(seq_cnt[k])};
            seq_cnt[k]++;
            pq[k].push_back(w);
            exp_q[k].push_back(w);
        end
    endtask

    task automatic clear_queues();
        for (int k = 0; k < NR; k++) begin
            pq[k].delete();
            exp_q[k].delete();
            wait_cnt[k] = 0;
        end
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        trace.delete();
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (pq[k].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk_i);
            done = all_empty() && !busy_o;
        end
        check_eq("drain_done", done, 1'b1);
    endtask

    task automatic build_runs();
        int cur;
        cur = -1;
        run_port.delete();
        run_len.delete();
        foreach (xfer_log[i]) begin
            if (xfer_log[i] < 0) begin
                cur = -1;
            end else if (xfer_log[i] == cur) begin
                run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            end else begin
                run_port.push_back(xfer_log[i]);
                run_len.push_back(1);
                cur = xfer_log[i];
            end
        end
    endtask

    task automatic expect_run(input string tag, input int idx, input int port, input int len);
        if (idx < run_port.size()) begin
            check_eq({tag, "_port"}, 64'(run_port[idx]), 64'(port));
            check_eq({tag, "_len"}, 64'(run_len[idx]), 64'(len));
        end else begin
            check_eq({tag, "_missing"}, 64'(run_port.size()), 64'(idx+1));
        end
    endtask

    // Producers: present the head of each queue, plus the FIFO full flag.
    initial begin
        valid_i     = '0;
        data_i      = '0;
        fifo_full_i = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            for (int k = 0; k < NR; k++) begin
                valid_i[k] = en[k] && (pq[k].size() > 0);
                data_i[k*DW +: DW] = (pq[k].size() > 0) ? pq[k][0] : '0;
            end
            fifo_full_i = full_knob | (rand_full && ($urandom_range(3, 0) == 0));
        end
    end

    task automatic sample_cycle();
        logic [NR-1:0] xfer;
        logic [DW-1:0] exp_w;
        int p;
        xfer = valid_i & ready_o;
        p = -1;
        for (int k = 0; k < NR; k++) begin
            if (xfer[k]) p = k;
        end
        if (fifo_full_i) check_eq("no_write_when_full", fifo_write_o, 1'b0);
        if (!busy_o) begin
            check_eq("idle_ready", 64'(ready_o), 64'd0);
            check_eq("idle_write", fifo_write_o, 1'b0);
        end
        check_eq("write_eq_handshake", fifo_write_o, |xfer);
        if (p >= 0) begin
            check_eq("one_xfer", 64'($countones(xfer)), 64'd1);
            check_eq("grant_id", 64'(grant_id_o), 64'(p));
            if (exp_q[p].size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q[p].size()), 64'd1);
            end else begin
                exp_w = exp_q[p].pop_front();
                check_eq("sb_data", fifo_wr_data_o, exp_w);
            end
            void'(pq[p].pop_front());
            xfer_log.push_back(p);
        end else if (!busy_o) begin
            xfer_log.push_back(-1);
        end
        for (int k = 0; k < NR; k++) begin
            if (!valid_i[k]) begin
                wait_cnt[k] = 0;
            end else if (k == p) begin
                check_eq("wait_bound", (wait_cnt[k] <= WAIT_BOUND), 1'b1);
                wait_cnt[k] = 0;
            end else if (p >= 0) begin
                wait_cnt[k]++;
            end
        end
        if (trace_on) trace.push_back((p >= 0) ? p : (busy_o ? 100 : 200));
    endtask

    // Monitor: sample just before each rising edge, once inputs have settled.
    initial begin
        forever begin
            @(negedge clk_i);
            #4;
            if (rst_n_i) sample_cycle();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t1 [9] = '{200, 0, 0, 0, 0, 200, 0, 0, 100};
    int cnt;

    initial begin
        // Reset state, while held and just after release.
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_ready", 64'(ready_o), 64'd0);
        check_eq("rst_write", fifo_write_o, 1'b0);
        check_eq("rst_grant", 64'(grant_id_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #4;
        check_eq("post_rst_busy", busy_o, 1'b0);
        @(negedge clk_i);

        // Single port, 6 words: 4 writes, one IDLE cycle, 2 writes, release.
        scen = 8'd1;
        clear_logs();
        trace_on = 1'b1;
        push_words(0, 6);
        wait_drain(100);
        trace_on = 1'b0;
        check_eq("s1_trace_len", (trace.size() >= 9), 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i < trace.size()) check_eq($sformatf("s1_trace%0d", i), 64'(trace[i]), 64'(t1[i]));
        end

        // All ports busy from reset: grants 0,1,2,3,0,1,2,3 with 4 words each.
        @(negedge clk_i);
        rst_n_i = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        scen = 8'd2;
        clear_logs();
        for (int k = 0; k < NR; k++) push_words(k, 8);
        wait_drain(300);
        build_runs();
        check_eq("s2_run_count", 64'(run_port.size()), 64'd8);
        for (int i = 0; i < 8; i++) expect_run($sformatf("s2_run%0d", i), i, i % NR, MB);

        // Full stall after word 2 for 5 cycles; the burst resumes with words 3 and 4.
        scen = 8'd3;
        clear_logs();
        push_words(0, 6);
        cnt = 0;
        while (pq[0].size() > 4 && cnt < 100) begin
            @(negedge clk_i);
            cnt++;
        end
        check_eq("s3_two_words_out", 64'(pq[0].size()), 64'd4);
        full_knob = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            check_eq("s3_stall_ready", 64'(ready_o), 64'd0);
            check_eq("s3_stall_write", fifo_write_o, 1'b0);
            @(negedge clk_i);
        end
        full_knob = 1'b0;
        wait_drain(100);
        build_runs();
        check_eq("s3_run_count", 64'(run_port.size()), 64'd2);
        expect_run("s3_run0", 0, 0, 4);
        expect_run("s3_run1", 1, 0, 2);

        // Early release by port 2 after one word: port 3 next, then port 0.
        scen = 8'd4;
        clear_logs();
        push_words(2, 1);
        push_words(3, 2);
        push_words(0, 2);
        wait_drain(100);
        build_runs();
        expect_run("s4_run0", 0, 2, 1);
        expect_run("s4_run1", 1, 3, 2);
        expect_run("s4_run2", 2, 0, 2);

        // Reset mid-burst (pointer sitting at 3), then 1010 must go to port 1 first.
        scen = 8'd5;
        clear_logs();
        push_words(2, 1);
        wait_drain(100);
        push_words(3, 4);
        cnt = 0;
        while (pq[3].size() > 3 && cnt < 100) begin
            @(negedge clk_i);
            cnt++;
        end
        check_eq("s5_one_word_out", 64'(pq[3].size()), 64'd3);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("s5_rst_busy", busy_o, 1'b0);
        check_eq("s5_rst_ready", 64'(ready_o), 64'd0);
        check_eq("s5_rst_write", fifo_write_o, 1'b0);
        check_eq("s5_rst_grant", 64'(grant_id_o), 64'd0);
        clear_queues();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        clear_logs();
        push_words(1, 2);
        push_words(3, 2);
        wait_drain(100);
        build_runs();
        expect_run("s5_run0", 0, 1, 2);
        expect_run("s5_run1", 1, 3, 2);

        // Random traffic with random FIFO-full and random valid drops.
        scen = 8'd6;
        clear_logs();
        rand_full = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(7, 0) == 0 && pq[k].size() < 6) push_words(k, 1);
                en[k] = ($urandom_range(15, 0) != 0);
            end
        end
        rand_full = 1'b0;
        en = '1;
        wait_drain(500);
        for (int k = 0; k < NR; k++) check_eq($sformatf("s6_sb_empty%0d", k), 64'(exp_q[k].size()), 64'd0);
        cnt = 0;
        foreach (xfer_log[i]) begin
            if (xfer_log[i] >= 0) cnt++;
        end
        check_eq("s6_traffic", (cnt > 500), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
